// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract, one full-adder cell and carry flop shared LSB-first over WIDTH steps
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_next;
    logic [WIDTH-1:0] op_a, op_b;
    logic [CW-1:0]    cnt;
    logic             carry, s, c, last, accept;
    assign s      = op_a[0] ^ op_b[0] ^ carry;
    assign c      = (op_a[0] & op_b[0]) | ((op_a[0] ^ op_b[0]) & carry);
    assign last   = (cnt == CW'(WIDTH - 1));
    assign accept = start && (state != RUN);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    always_comb begin
        state_next = state;
        if (state == RUN) state_next = last ? DONE : RUN;
        else state_next = accept ? RUN : IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_next;
    end
    // Operand/result datapath; sum fills from the top as bits are produced LSB first
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == RUN) begin
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            sum   <= WIDTH'({s, sum} >> 1);
            carry <= c;
            cnt   <= cnt + CW'(1);
            if (last) begin
                cout <= c;
                ovf  <= c ^ carry;
            end
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and sweep checks of the serial adder at WIDTH=8 and WIDTH=1
module tb_serial_add_ctrl;
    logic       clk = 0, rst_n = 0;
    logic       start = 0, sub = 0;
    logic [7:0] a = 0, b = 0;
    logic       busy, done, cout, ovf;
    logic [7:0] sum;
    logic       s1_start = 0, s1_sub = 0, s1_a = 0, s1_b = 0;
    logic       s1_busy, s1_done, s1_sum, s1_cout, s1_ovf;
    int         tests = 0, fails = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );
    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1_start), .sub(s1_sub), .a(s1_a), .b(s1_b),
        .busy(s1_busy), .done(s1_done), .sum(s1_sum), .cout(s1_cout), .ovf(s1_ovf)
    );

    // Issues one WIDTH=8 op from a post-edge point and returns in the done cycle (or on timeout)
    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic sb,
                       output int lat, output logic busy_ok);
        a = x; b = y; sub = sb; start = 1;
        @(posedge clk); #1;
        start = 0;
        busy_ok = busy;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (!done && !busy) busy_ok = 0;
        end
    endtask

    task automatic test_reset;
        tests++;
        if ({busy, done, sum, cout, ovf} !== 12'h000) begin
            fails++;
            $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0", busy, done, sum, cout, ovf);
        end
        tests++;
        if ({s1_busy, s1_done, s1_sum, s1_cout, s1_ovf} !== 5'b0) begin
            fails++;
            $display("FAIL reset1: got %b, want 00000", {s1_busy, s1_done, s1_sum, s1_cout, s1_ovf});
        end
    endtask

    task automatic test_basic;
        int lat; logic bok;
        logic [7:0] va [4] = '{8'h5A, 8'h10, 8'h80, 8'h03};
        logic [7:0] vb [4] = '{8'h3C, 8'h20, 8'h01, 8'h04};
        logic       vs [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [9:0] ve [4] = '{{2'b01, 8'h96}, {2'b00, 8'hF0}, {2'b11, 8'h7F}, {2'b00, 8'h07}};
        for (int i = 0; i < 4; i++) begin
            op8(va[i], vb[i], vs[i], lat, bok);
            tests++;
            if (lat !== 8 || !bok || busy !== 1'b0) begin
                fails++;
                $display("FAIL timing%0d: latency=%0d busy_ok=%b busy_at_done=%b, want 8/1/0", i, lat, bok, busy);
            end
            tests++;
            if ({cout, ovf, sum} !== ve[i]) begin
                fails++;
                $display("FAIL result%0d: got cout=%b ovf=%b sum=%h, want %b %b %h", i, cout, ovf, sum, ve[i][9], ve[i][8], ve[i][7:0]);
            end
            @(posedge clk); #1;
            tests++;
            if (done !== 1'b0 || busy !== 1'b0 || sum !== ve[i][7:0]) begin
                fails++;
                $display("FAIL hold%0d: done=%b busy=%b sum=%h, want 0 0 %h", i, done, busy, sum, ve[i][7:0]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat; logic bok;
        op8(8'hFF, 8'h01, 1'b0, lat, bok);
        tests++;
        if (lat !== 8 || {cout, ovf, sum} !== {2'b10, 8'h00}) begin
            fails++;
            $display("FAIL b2b_first: lat=%0d cout=%b ovf=%b sum=%h, want 8 1 0 00", lat, cout, ovf, sum);
        end
        a = 8'h01; b = 8'h01; sub = 0; start = 1;
        @(posedge clk); #1;
        start = 0;
        tests++;
        if (busy !== 1'b1 || done !== 1'b0 || sum !== 8'h00) begin
            fails++;
            $display("FAIL b2b_load: busy=%b done=%b sum=%h, want 1 0 00", busy, done, sum);
        end
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        tests++;
        if (lat !== 8 || sum !== 8'h02 || cout !== 1'b0) begin
            fails++;
            $display("FAIL b2b_second: lat=%0d sum=%h cout=%b, want 8 02 0", lat, sum, cout);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored;
        int lat;
        a = 8'h12; b = 8'h34; sub = 0; start = 1;
        @(posedge clk); #1;
        start = 0;
        lat = 0;
        repeat (3) begin @(posedge clk); #1; lat++; end
        a = 8'hAA; b = 8'h55; sub = 1; start = 1;
        @(posedge clk); #1;
        lat++;
        start = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        tests++;
        if (lat !== 8 || sum !== 8'h46 || cout !== 1'b0 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL ignore_start: lat=%0d sum=%h cout=%b ovf=%b, want 8 46 0 0", lat, sum, cout, ovf);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midrun;
        int lat; logic bok; logic seen;
        a = 8'hF0; b = 8'h0F; sub = 0; start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 0;
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            fails++;
            $display("FAIL midrun_reset: busy=%b done=%b sum=%h cout=%b, want 0 0 00 0", busy, done, sum, cout);
        end
        rst_n = 1;
        seen = 0;
        repeat (10) begin @(posedge clk); #1; if (done || busy) seen = 1; end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL midrun_no_done: saw done/busy=%b after abort, want 0", seen);
        end
        op8(8'h03, 8'h04, 1'b0, lat, bok);
        tests++;
        if (lat !== 8 || sum !== 8'h07) begin
            fails++;
            $display("FAIL after_reset_op: lat=%0d sum=%h, want 8 07", lat, sum);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sweep8;
        int lat; logic bok;
        logic [7:0] x, y, yb; logic sb;
        logic [8:0] r; logic eo;
        for (int i = 0; i < 24; i++) begin
            x = 8'($urandom); y = 8'($urandom); sb = 1'($urandom);
            if (i == 0) begin x = 8'h00; y = 8'h00; sb = 1; end
            if (i == 1) begin x = 8'h7F; y = 8'h80; sb = 1; end
            yb = sb ? ~y : y;
            r = {1'b0, x} + {1'b0, yb} + {8'h00, sb};
            eo = (x[7] == yb[7]) && (r[7] != x[7]);
            op8(x, y, sb, lat, bok);
            tests++;
            if (lat !== 8 || {cout, sum} !== r || ovf !== eo) begin
                fails++;
                $display("FAIL sweep8_%0d: %h %s %h got lat=%0d cout=%b sum=%h ovf=%b, want 8 %b %h %b",
                         i, x, sb ? "-" : "+", y, lat, cout, sum, ovf, r[8], r[7:0], eo);
            end
            if (i % 3 == 0) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sweep1;
        int lat;
        logic x, y, yb, sb, eo;
        logic [1:0] r;
        for (int i = 0; i < 8; i++) begin
            {sb, x, y} = 3'(i);
            yb = sb ? ~y : y;
            r = {1'b0, x} + {1'b0, yb} + {1'b0, sb};
            eo = (x == yb) && (r[0] != x);
            s1_a = x; s1_b = y; s1_sub = sb; s1_start = 1;
            @(posedge clk); #1;
            s1_start = 0;
            tests++;
            if (s1_busy !== 1'b1 || s1_done !== 1'b0) begin
                fails++;
                $display("FAIL w1_busy%0d: busy=%b done=%b, want 1 0", i, s1_busy, s1_done);
            end
            lat = 0;
            while (!s1_done && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            tests++;
            if (lat !== 1 || {s1_cout, s1_sum} !== r || s1_ovf !== eo) begin
                fails++;
                $display("FAIL w1_%0d: sub=%b a=%b b=%b got lat=%0d cout=%b sum=%b ovf=%b, want 1 %b %b %b",
                         i, sb, x, y, lat, s1_cout, s1_sum, s1_ovf, r[1], r[0], eo);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        rst_n = 1;
        @(posedge clk); #1;
        test_basic;
        test_back_to_back;
        test_start_ignored;
        test_reset_midrun;
        test_sweep8;
        test_sweep1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
